// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and default bit period.
// State encoding widens to 3 bits when UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick
// on the last count; clr holds it at zero. Shared with the receiver.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter (8N1, or 8E1 when built with UART_TX_PARITY_EN): holding
// register fed by the C bus, separate shift register for the frame in flight.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              uart_tx_in,
  input  logic              uart_send_data,
  output logic              tx,
  output logic              busyFlag
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  // Handshake: uart_tx_in loads data_in every cycle it is high, in any state.
  // uart_send_data is a one-cycle request honoured only while busyFlag is low;
  // requests while busy are dropped, and busyFlag rises on the accepting edge.
  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] send_byte;
  logic              baud_tick;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (reset),
    .en  (state_q != IDLE),
    .clr (state_q == IDLE),
    .tick(baud_tick)
  );

  // Same-cycle load and send transmits the new byte, not the stale one.
  assign send_byte = uart_tx_in ? data_in : hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= UART_IDLE_LEVEL;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = uart_tx_in ? data_in : hold_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (uart_send_data) begin
          state_d  = START;
          shift_d  = send_byte;
          idx_d    = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^send_byte;
`endif
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx and busyFlag are registered from the next state so both change on the
  // same edge as the state and the line never glitches.
  always_comb begin
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      STOP:    tx_d = UART_STOP_LEVEL;
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  assign tx       = tx_q;
  assign busyFlag = busy_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter that answers the control unit's STORE-to-0xFE sequence. It captures the byte on the C-register output bus on uart_tx_in and starts an 8N1 frame on uart_send_data. It holds busyFlag high until the stop bit completes, and the control unit stalls its step counter on that flag. It sits between the C-register output bus and the board TX pin.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range 2..65535.
DATA_W, 8, data bits per frame; sent LSB first.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
data_in  input  DATA_W  byte from the C-register output bus.
uart_tx_in  input  1  load data_in into the holding register this cycle.
uart_send_data  input  1  start a frame from the holding register.
tx  output  1  serial line; idles high.
busyFlag  output  1  high while a frame is in flight.

Behaviour:
- Reset is asynchronous and active-high, with one clock: clk. Reset values: tx=1, busyFlag=0, state=IDLE, baud counter=0, bit index=0, holding register=0, shift register=0.
- Holding register:
  - Loads data_in on any clk edge with uart_tx_in=1, in any state.
  - A load during a frame does not disturb the frame in progress, because the frame shifts from a separate shift register.
- FSM states:
  - IDLE: tx=1, busyFlag=0. If uart_send_data=1, the next edge copies the holding register into the shift register and goes to START.
  - If uart_tx_in and uart_send_data are both 1 in the same cycle, the shift register takes data_in directly (bypass), so the new byte is sent.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit DATA_W-1, go to STOP (or PARITY when the optional feature is built).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- busyFlag timing:
  - busyFlag is registered and equals (state != IDLE).
  - It rises on the edge that samples uart_send_data, the same edge on which tx falls.
  - It stays high exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
  - It falls on the edge that returns to IDLE. A new send is accepted on the cycle busyFlag is first low.
- uart_send_data while busyFlag=1 is ignored; it is not queued.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
  - It is $clog2(CLKS_PER_BIT) bits wide.
  - It is held at 0 in IDLE.
- tx is driven from a flop, never from combinational logic, so there are no glitches.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronous) and busyFlag goes to 0. The frame is dropped and not resumed after reset releases.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit, the XOR of all data bits, for CLKS_PER_BIT cycles. The frame becomes 8E1 and busyFlag lasts 11*CLKS_PER_BIT.
- Undefined: the PARITY state and its logic are absent and the frame is 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3, plus PARITY=3'd4 under the macro; the state is 3 bits wide when enabled);
  - constants UART_IDLE_LEVEL=1, UART_START_LEVEL=0, UART_STOP_LEVEL=1;
  - the default CLKS_PER_BIT.
- One natural sub-module: uart_baud_tick. It is a counter with an enable and a synchronous clear, and it emits a one-cycle tick at CLKS_PER_BIT-1. The UART receiver reuses it later.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: tx=1 and busyFlag=0 for 50 cycles with no inputs asserted.
- uart_tx_in with data_in=0xA5, then next cycle uart_send_data:
  - busyFlag high for exactly 40 cycles;
  - tx samples at bit centres read 0, 1,0,1,0,0,1,0,1, 1.
- Same-cycle uart_tx_in and uart_send_data with data_in=0x3C, while the holding register holds 0x00: the frame carries 0x3C.
- Mid-frame inputs:
  - uart_send_data pulsed at cycle 12 of a frame: no second frame follows.
  - uart_tx_in with 0xFF at cycle 12: the current frame stays unchanged, and the next send transmits 0xFF.
- Reset asserted at cycle 20 of a frame: tx=1 and busyFlag=0 within the same cycle (asynchronous). After release, a send of 0x55 produces a clean full frame.
- With UART_TX_PARITY_EN, send 0x07: the parity bit is 1 and busyFlag lasts 44 cycles. Send 0x03: the parity bit is 0.
